// File: rtl/zap_memory_stage.sv
// rtl/zap_memory_stage.sv - memory stage: registers ALU results and aligned load data for writeback
// All outputs are flops; reset > clear > stall > capture on every edge.
module zap_memory_stage #(
    parameter int PHY_REGS = 46,
    parameter int FLAG_WDT = 32,
    localparam int IW = $clog2(PHY_REGS)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_clear_from_writeback,
    input  logic                i_data_stall,
    input  logic                i_alu_valid,
    input  logic [IW-1:0]       i_alu_wr_index,
    input  logic [31:0]         i_alu_result,
    input  logic [FLAG_WDT-1:0] i_alu_flags,
    input  logic                i_alu_thumb,
    input  logic [31:0]         i_alu_pc_plus_8,
    input  logic                i_alu_irq,
    input  logic                i_alu_fiq,
    input  logic                i_alu_instr_abt,
    input  logic                i_alu_swi,
    input  logic                i_alu_und,
    input  logic                i_mem_load,
    input  logic [IW-1:0]       i_mem_wr_index,
    input  logic [1:0]          i_mem_addr_lsb,
    input  logic [1:0]          i_mem_size,
    input  logic                i_mem_signed,
    input  logic [31:0]         i_dcache_data,
    input  logic                i_dcache_abort,
    output logic                o_valid,
    output logic [IW-1:0]       o_wr_index,
    output logic [31:0]         o_wr_data,
    output logic [FLAG_WDT-1:0] o_flags,
    output logic                o_thumb,
    output logic                o_mem_load_ff,
    output logic [IW-1:0]       o_wr_index_1,
    output logic [31:0]         o_wr_data_1,
    output logic [31:0]         o_pc_plus_8_ff,
    output logic                o_irq,
    output logic                o_fiq,
    output logic                o_instr_abt,
    output logic                o_swi,
    output logic                o_und,
    output logic                o_data_abt
);

    // Highest physical index is the read-as-zero sink for "no write".
    localparam logic [IW-1:0]       PHY_RAZ_REGISTER = IW'(PHY_REGS - 1);
    // SVC mode, IRQ and FIQ masked, ARM state.
    localparam logic [FLAG_WDT-1:0] FLAGS_RESET      = FLAG_WDT'(32'h0000_00D3);

    logic                valid_q;
    logic [IW-1:0]       wr_index_q;
    logic [31:0]         wr_data_q;
    logic [FLAG_WDT-1:0] flags_q;
    logic                thumb_q;
    logic                mem_load_q;
    logic [IW-1:0]       wr_index_1_q;
    logic [31:0]         wr_data_1_q;
    logic [31:0]         pc_plus_8_q;
    logic                irq_q;
    logic                fiq_q;
    logic                instr_abt_q;
    logic                swi_q;
    logic                und_q;
    logic                data_abt_q;

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [31:0] wr_data_1_d;
    logic        load_capture_d;

    always_comb begin
        half_sel = i_mem_addr_lsb[1] ? i_dcache_data[31:16] : i_dcache_data[15:0];
        byte_sel = i_dcache_data[7:0];
        case (i_mem_addr_lsb)
            2'd1:    byte_sel = i_dcache_data[15:8];
            2'd2:    byte_sel = i_dcache_data[23:16];
            2'd3:    byte_sel = i_dcache_data[31:24];
            default: byte_sel = i_dcache_data[7:0];
        endcase

        wr_data_1_d = i_dcache_data;
        case (i_mem_size)
            2'b01:   wr_data_1_d = {{16{i_mem_signed & half_sel[15]}}, half_sel};
            2'b10:   wr_data_1_d = {{24{i_mem_signed & byte_sel[7]}}, byte_sel};
            default: begin
                // Unaligned word loads rotate the addressed byte into bit 0.
                case (i_mem_addr_lsb)
                    2'd1:    wr_data_1_d = {i_dcache_data[7:0],  i_dcache_data[31:8]};
                    2'd2:    wr_data_1_d = {i_dcache_data[15:0], i_dcache_data[31:16]};
                    2'd3:    wr_data_1_d = {i_dcache_data[23:0], i_dcache_data[31:24]};
                    default: wr_data_1_d = i_dcache_data;
                endcase
            end
        endcase

        // An aborted load must not write its destination.
        load_capture_d = i_mem_load & i_alu_valid & ~i_dcache_abort;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q      <= 1'b0;
            wr_index_q   <= PHY_RAZ_REGISTER;
            wr_data_q    <= 32'd0;
            flags_q      <= FLAGS_RESET;
            thumb_q      <= 1'b0;
            mem_load_q   <= 1'b0;
            wr_index_1_q <= PHY_RAZ_REGISTER;
            wr_data_1_q  <= 32'd0;
            pc_plus_8_q  <= 32'd0;
            irq_q        <= 1'b0;
            fiq_q        <= 1'b0;
            instr_abt_q  <= 1'b0;
            swi_q        <= 1'b0;
            und_q        <= 1'b0;
            data_abt_q   <= 1'b0;
        end else if (i_clear_from_writeback) begin
            valid_q      <= 1'b0;
            wr_index_q   <= PHY_RAZ_REGISTER;
            mem_load_q   <= 1'b0;
            wr_index_1_q <= PHY_RAZ_REGISTER;
            irq_q        <= 1'b0;
            fiq_q        <= 1'b0;
            instr_abt_q  <= 1'b0;
            swi_q        <= 1'b0;
            und_q        <= 1'b0;
            data_abt_q   <= 1'b0;
        end else if (!i_data_stall) begin
            valid_q      <= i_alu_valid;
            wr_index_q   <= i_alu_wr_index;
            wr_data_q    <= i_alu_result;
            flags_q      <= i_alu_flags;
            thumb_q      <= i_alu_thumb;
            pc_plus_8_q  <= i_alu_pc_plus_8;
            irq_q        <= i_alu_irq & i_alu_valid;
            fiq_q        <= i_alu_fiq & i_alu_valid;
            instr_abt_q  <= i_alu_instr_abt & i_alu_valid;
            swi_q        <= i_alu_swi & i_alu_valid;
            und_q        <= i_alu_und & i_alu_valid;
            data_abt_q   <= i_dcache_abort & i_mem_load & i_alu_valid;
            mem_load_q   <= load_capture_d;
            wr_index_1_q <= load_capture_d ? i_mem_wr_index : PHY_RAZ_REGISTER;
            wr_data_1_q  <= load_capture_d ? wr_data_1_d : 32'd0;
        end
    end

    assign o_valid        = valid_q;
    assign o_wr_index     = wr_index_q;
    assign o_wr_data      = wr_data_q;
    assign o_flags        = flags_q;
    assign o_thumb        = thumb_q;
    assign o_mem_load_ff  = mem_load_q;
    assign o_wr_index_1   = wr_index_1_q;
    assign o_wr_data_1    = wr_data_1_q;
    assign o_pc_plus_8_ff = pc_plus_8_q;
    assign o_irq          = irq_q;
    assign o_fiq          = fiq_q;
    assign o_instr_abt    = instr_abt_q;
    assign o_swi          = swi_q;
    assign o_und          = und_q;
    assign o_data_abt     = data_abt_q;

endmodule

// File: tb/tb_zap_memory_stage.sv
// tb/tb_zap_memory_stage.sv - self-checking bench for zap_memory_stage
module tb_zap_memory_stage;

    localparam int PHY_REGS = 46;
    localparam int FLAG_WDT = 32;
    localparam int IW = $clog2(PHY_REGS);
    localparam logic [IW-1:0] RAZ = IW'(PHY_REGS - 1);

    logic                i_clk = 1'b0;
    logic                i_reset = 1'b1;
    logic                i_clear_from_writeback = 1'b0;
    logic                i_data_stall = 1'b0;
    logic                i_alu_valid = 1'b0;
    logic [IW-1:0]       i_alu_wr_index = '0;
    logic [31:0]         i_alu_result = '0;
    logic [FLAG_WDT-1:0] i_alu_flags = '0;
    logic                i_alu_thumb = 1'b0;
    logic [31:0]         i_alu_pc_plus_8 = '0;
    logic                i_alu_irq = 1'b0;
    logic                i_alu_fiq = 1'b0;
    logic                i_alu_instr_abt = 1'b0;
    logic                i_alu_swi = 1'b0;
    logic                i_alu_und = 1'b0;
    logic                i_mem_load = 1'b0;
    logic [IW-1:0]       i_mem_wr_index = '0;
    logic [1:0]          i_mem_addr_lsb = '0;
    logic [1:0]          i_mem_size = '0;
    logic                i_mem_signed = 1'b0;
    logic [31:0]         i_dcache_data = '0;
    logic                i_dcache_abort = 1'b0;
    logic                o_valid;
    logic [IW-1:0]       o_wr_index;
    logic [31:0]         o_wr_data;
    logic [FLAG_WDT-1:0] o_flags;
    logic                o_thumb;
    logic                o_mem_load_ff;
    logic [IW-1:0]       o_wr_index_1;
    logic [31:0]         o_wr_data_1;
    logic [31:0]         o_pc_plus_8_ff;
    logic                o_irq, o_fiq, o_instr_abt, o_swi, o_und, o_data_abt;

    zap_memory_stage #(.PHY_REGS(PHY_REGS), .FLAG_WDT(FLAG_WDT)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_clear_from_writeback(i_clear_from_writeback), .i_data_stall(i_data_stall),
        .i_alu_valid(i_alu_valid), .i_alu_wr_index(i_alu_wr_index),
        .i_alu_result(i_alu_result), .i_alu_flags(i_alu_flags),
        .i_alu_thumb(i_alu_thumb), .i_alu_pc_plus_8(i_alu_pc_plus_8),
        .i_alu_irq(i_alu_irq), .i_alu_fiq(i_alu_fiq), .i_alu_instr_abt(i_alu_instr_abt),
        .i_alu_swi(i_alu_swi), .i_alu_und(i_alu_und),
        .i_mem_load(i_mem_load), .i_mem_wr_index(i_mem_wr_index),
        .i_mem_addr_lsb(i_mem_addr_lsb), .i_mem_size(i_mem_size),
        .i_mem_signed(i_mem_signed), .i_dcache_data(i_dcache_data),
        .i_dcache_abort(i_dcache_abort),
        .o_valid(o_valid), .o_wr_index(o_wr_index), .o_wr_data(o_wr_data),
        .o_flags(o_flags), .o_thumb(o_thumb), .o_mem_load_ff(o_mem_load_ff),
        .o_wr_index_1(o_wr_index_1), .o_wr_data_1(o_wr_data_1),
        .o_pc_plus_8_ff(o_pc_plus_8_ff),
        .o_irq(o_irq), .o_fiq(o_fiq), .o_instr_abt(o_instr_abt), .o_swi(o_swi),
        .o_und(o_und), .o_data_abt(o_data_abt)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Value a load delivers to the register file, from the architectural rules.
    function automatic logic [31:0] load_value(input logic [31:0] d, input logic [1:0] k,
                                               input logic [1:0] size, input logic sgn);
        logic [63:0] dbl;
        logic [31:0] v;
        dbl = {d, d} >> (8 * k);
        v = dbl[31:0];
        if (size == 2'b01) begin
            v = (d >> (k[1] ? 16 : 0)) & 32'h0000_FFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
        end else if (size == 2'b10) begin
            v = (d >> (8 * k)) & 32'h0000_00FF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        end
        return v;
    endfunction

    // Expected register bundle; exceptions packed {irq,fiq,iabt,swi,und,dabt}.
    logic        m_live = 1'b0;
    logic        m_valid, m_load, m_thumb;
    logic [IW-1:0] m_idx, m_idx1;
    logic [31:0] m_data, m_data1, m_pc;
    logic [FLAG_WDT-1:0] m_flags;
    logic [5:0]  m_exc;

    always @(posedge i_clk) begin
        if (i_reset) begin
            m_live <= 1'b1;
            m_valid <= 0; m_load <= 0; m_thumb <= 0; m_exc <= '0;
            m_idx <= RAZ; m_idx1 <= RAZ; m_data <= 0; m_data1 <= 0; m_pc <= 0;
            m_flags <= FLAG_WDT'(32'h0000_00D3);
        end else if (i_clear_from_writeback) begin
            m_valid <= 0; m_load <= 0; m_exc <= '0; m_idx <= RAZ; m_idx1 <= RAZ;
        end else if (!i_data_stall) begin
            m_valid <= i_alu_valid;
            m_idx <= i_alu_wr_index;
            m_data <= i_alu_result;
            m_flags <= i_alu_flags;
            m_thumb <= i_alu_thumb;
            m_pc <= i_alu_pc_plus_8;
            m_exc <= {i_alu_irq, i_alu_fiq, i_alu_instr_abt, i_alu_swi, i_alu_und,
                      i_dcache_abort & i_mem_load} & {6{i_alu_valid}};
            if (i_alu_valid && i_mem_load && !i_dcache_abort) begin
                m_load <= 1; m_idx1 <= i_mem_wr_index;
                m_data1 <= load_value(i_dcache_data, i_mem_addr_lsb, i_mem_size, i_mem_signed);
            end else begin
                m_load <= 0; m_idx1 <= RAZ; m_data1 <= 0;
            end
        end
    end

    always @(negedge i_clk) begin
        if (m_live) begin
            check("cmp_valid", 32'(o_valid), 32'(m_valid));
            check("cmp_wr_index", 32'(o_wr_index), 32'(m_idx));
            check("cmp_wr_data", o_wr_data, m_data);
            check("cmp_flags", 32'(o_flags), 32'(m_flags));
            check("cmp_thumb", 32'(o_thumb), 32'(m_thumb));
            check("cmp_pc", o_pc_plus_8_ff, m_pc);
            check("cmp_mem_load", 32'(o_mem_load_ff), 32'(m_load));
            check("cmp_wr_index_1", 32'(o_wr_index_1), 32'(m_idx1));
            check("cmp_wr_data_1", o_wr_data_1, m_data1);
            check("cmp_exc", 32'({o_irq, o_fiq, o_instr_abt, o_swi, o_und, o_data_abt}),
                  32'(m_exc));
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic [IW-1:0] idx, input logic [31:0] res);
        i_alu_valid = v; i_alu_wr_index = idx; i_alu_result = res;
    endtask

    task automatic load(input logic ld, input logic [1:0] k, input logic [1:0] size,
                        input logic sgn, input logic [31:0] d, input logic abt);
        i_mem_load = ld; i_mem_wr_index = 6'd7; i_mem_addr_lsb = k; i_mem_size = size;
        i_mem_signed = sgn; i_dcache_data = d; i_dcache_abort = abt;
    endtask

    initial begin
        i_reset = 1'b1;
        step(); step();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_wr_index", 32'(o_wr_index), 32'd45);
        check("rst_wr_index_1", 32'(o_wr_index_1), 32'd45);
        check("rst_mode", 32'(o_flags[4:0]), 32'h13);
        check("rst_ift", 32'(o_flags[7:5]), 32'b110);
        check("rst_exc", 32'({o_irq, o_fiq, o_instr_abt, o_swi, o_und, o_data_abt}), 32'd0);
        i_reset = 1'b0;

        alu(1, 6'd3, 32'h1234_5678); load(0, 0, 0, 0, 32'h0, 0);
        i_alu_flags = 32'h6000_0010; i_alu_pc_plus_8 = 32'h0000_1008;
        step();
        check("op_valid", 32'(o_valid), 32'd1);
        check("op_wr_index", 32'(o_wr_index), 32'd3);
        check("op_wr_data", o_wr_data, 32'h1234_5678);
        check("op_mem_load", 32'(o_mem_load_ff), 32'd0);

        load(1, 2'd1, 2'b00, 0, 32'hAABB_CCDD, 0); step();
        check("ld_word_k1", o_wr_data_1, 32'hDDAA_BBCC);
        check("ld_mem_load", 32'(o_mem_load_ff), 32'd1);
        check("ld_index_1", 32'(o_wr_index_1), 32'd7);
        load(1, 2'd1, 2'b10, 1, 32'hAABB_CCDD, 0); step();
        check("ld_sbyte_k1", o_wr_data_1, 32'hFFFF_FFCC);
        load(1, 2'd2, 2'b01, 0, 32'hAABB_CCDD, 0); step();
        check("ld_uhalf_k2", o_wr_data_1, 32'h0000_AABB);
        load(1, 2'd0, 2'b01, 1, 32'hAABB_CCDD, 0); step();
        check("ld_shalf_k0", o_wr_data_1, 32'hFFFF_CCDD);
        load(1, 2'd3, 2'b11, 0, 32'hAABB_CCDD, 0); step();
        check("ld_size3_k3", o_wr_data_1, 32'hBBCC_DDAA);
        load(1, 2'd3, 2'b01, 0, 32'h8001_7F02, 0); step();
        check("ld_uhalf_k3", o_wr_data_1, 32'h0000_8001);

        alu(1, 6'd5, 32'h1111_1111); load(0, 0, 0, 0, 0, 0); step();
        i_data_stall = 1;
        for (int i = 0; i < 3; i++) begin
            alu(1, 6'(10 + i), 32'hA000_0000 + i);
            load(1, 2'(i), 2'b00, 0, 32'hDEAD_0000 + i, 1);
            step();
            check("stall_hold_data", o_wr_data, 32'h1111_1111);
            check("stall_hold_idx", 32'(o_wr_index), 32'd5);
            check("stall_hold_dabt", 32'(o_data_abt), 32'd0);
        end
        i_data_stall = 0; alu(1, 6'd6, 32'h2222_2222); load(0, 0, 0, 0, 0, 0); step();
        check("stall_release", o_wr_data, 32'h2222_2222);

        i_clear_from_writeback = 1; i_data_stall = 1; load(1, 0, 0, 0, 32'h1, 0); step();
        check("clr_valid", 32'(o_valid), 32'd0);
        check("clr_mem_load", 32'(o_mem_load_ff), 32'd0);
        check("clr_wr_index", 32'(o_wr_index), 32'd45);
        i_clear_from_writeback = 0; i_data_stall = 0;

        load(1, 0, 0, 0, 32'h5555_5555, 1); step();
        check("abt_data_abt", 32'(o_data_abt), 32'd1);
        check("abt_mem_load", 32'(o_mem_load_ff), 32'd0);
        load(0, 0, 0, 0, 0, 0); i_alu_irq = 1; step();
        check("irq_valid", 32'(o_irq), 32'd1);
        alu(0, 6'd3, 32'h0); step();
        check("irq_invalid", 32'(o_irq), 32'd0);
        check("irq_invalid_valid", 32'(o_valid), 32'd0);

        // Mixed vectors covered by the model compare.
        for (int i = 0; i < 60; i++) begin
            i_clear_from_writeback = ($urandom_range(0, 9) == 0);
            i_data_stall = ($urandom_range(0, 3) == 0);
            i_reset = ($urandom_range(0, 29) == 0);
            alu(1'($urandom), 6'($urandom_range(0, 45)), $urandom);
            i_alu_flags = $urandom; i_alu_thumb = 1'($urandom); i_alu_pc_plus_8 = $urandom;
            {i_alu_irq, i_alu_fiq, i_alu_instr_abt, i_alu_swi, i_alu_und} = 5'($urandom);
            load(1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), $urandom,
                 ($urandom_range(0, 4) == 0));
            i_mem_wr_index = 6'($urandom_range(0, 45));
            step();
        end
        i_reset = 0; i_clear_from_writeback = 0; i_data_stall = 0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zap_memory_stage.md
Name: zap_memory_stage

Overview:
Pipeline stage directly upstream of the writeback stage.
- Registers the ALU-stage result, flags, PC+8 and exception indicators.
- Aligns and extends data-cache load data and registers it.
- Presents one registered bundle per instruction to writeback: the valid strobe, dual write ports, flags, the load indicator and the exception vector.
- Honours the global data stall and the flush from writeback.

Parameters:
PHY_REGS, 46, number of physical registers; index width is IW = $clog2(PHY_REGS).
FLAG_WDT, 32, CPSR/flags width.

Ports:
i_clk  in  1  core clock
i_reset  in  1  synchronous, active-high reset
i_clear_from_writeback  in  1  flush: invalidate stage contents
i_data_stall  in  1  global data stall: hold all outputs
i_alu_valid  in  1  ALU stage holds a valid instruction
i_alu_wr_index  in  IW  arithmetic-port destination
i_alu_result  in  32  arithmetic-port data
i_alu_flags  in  FLAG_WDT  flags after the instruction
i_alu_thumb  in  1  instruction is Thumb
i_alu_pc_plus_8  in  32  PC+8 of the instruction
i_alu_irq, i_alu_fiq, i_alu_instr_abt, i_alu_swi, i_alu_und  in  1 each  exception tags carried with the instruction
i_mem_load  in  1  instruction is a load
i_mem_wr_index  in  IW  load destination
i_mem_addr_lsb  in  2  load address [1:0]
i_mem_size  in  2  00 word, 01 halfword, 10 byte, 11 treated as word
i_mem_signed  in  1  sign-extend halfword/byte
i_dcache_data  in  32  raw read data, valid when i_data_stall=0
i_dcache_abort  in  1  data abort, valid when i_data_stall=0
o_valid  out  1  to writeback i_valid
o_wr_index  out  IW  to i_wr_index
o_wr_data  out  32  to i_wr_data
o_flags  out  FLAG_WDT  to i_flags
o_thumb  out  1  to i_thumb
o_mem_load_ff  out  1  to i_mem_load_ff
o_wr_index_1  out  IW  to i_wr_index_1
o_wr_data_1  out  32  to i_wr_data_1 (aligned load data)
o_pc_plus_8_ff  out  32  to i_pc_buf_ff
o_irq, o_fiq, o_instr_abt, o_swi, o_und, o_data_abt  out  1 each  to the writeback exception inputs

Behaviour:
Latency and update priority:
- Latency is exactly 1 cycle. All outputs are flops; no combinational input-to-output path.
- Per-edge priority is reset > i_clear_from_writeback > i_data_stall > capture.

Reset:
- o_valid, o_mem_load_ff and all exception outputs = 0.
- o_wr_index = o_wr_index_1 = PHY_RAZ_REGISTER.
- o_wr_data, o_wr_data_1 and o_pc_plus_8_ff = 0.
- o_flags = SVC mode with I=1, F=1, T=0, matching the CPSR reset value.
- o_thumb = 0.

Clear (i_clear_from_writeback=1, no reset):
- o_valid, o_mem_load_ff and all exception outputs = 0.
- Both write indices = PHY_RAZ_REGISTER.
- Data, flags and PC outputs are don't-care; they are held.
- Clear wins over a simultaneous stall.

Stall (i_data_stall=1):
- Every output holds its value.
- i_dcache_data and i_dcache_abort are ignored.

Capture (otherwise):
- o_valid = i_alu_valid.
- Exception outputs = respective i_alu_* AND i_alu_valid.
- o_data_abt = i_dcache_abort & i_mem_load & i_alu_valid.
- o_mem_load_ff = i_mem_load & i_alu_valid & ~i_dcache_abort.
- Index, data, flags, thumb and PC outputs are copied from their inputs.

Load alignment (o_wr_data_1 at capture), with k = i_mem_addr_lsb:
- Word: i_dcache_data rotated right by 8*k (ARM unaligned LDR rotation).
- Halfword: select bits [31:16] if k[1] else [15:0]; k[0] is ignored. Zero-extend, or sign-extend bit 15 when i_mem_signed.
- Byte: select byte k. Zero-extend, or sign-extend bit 7 when i_mem_signed.
- When no load is captured, o_wr_data_1 = 0 and o_wr_index_1 = PHY_RAZ_REGISTER.

Further rules:
- Reset or clear asserted mid-stall discards the stalled instruction; there is no replay.
- Valid-low input yields o_valid=0 and zero exceptions; data outputs are don't-care.

Test Plan:
- Reset held 2 cycles → o_valid=0, o_wr_index=o_wr_index_1=PHY_RAZ_REGISTER, o_flags mode=SVC with I=F=1, T=0, all exceptions 0.
- Valid ALU op, index 3, result 0x12345678, no load → next cycle o_valid=1, o_wr_index=3, o_wr_data=0x12345678, o_mem_load_ff=0.
- Load, dcache data 0xAABBCCDD, k=1: word → 0xDDAABBCC; signed byte → 0xFFFFFFCC; unsigned half with k=2 → 0x0000AABB; signed half with k=0 → 0xFFFFCCDD.
- Stall held 3 cycles with changing inputs → outputs constant; stall release captures the current inputs one cycle later.
- Clear and stall asserted together while o_valid=1 → next cycle o_valid=0, o_mem_load_ff=0, exceptions 0.
- Load with i_dcache_abort=1 → o_data_abt=1, o_mem_load_ff=0. Valid op with i_alu_irq=1 → o_irq=1. Same op with i_alu_valid=0 → o_irq=0.
